// File: rtl/mem_interface.sv
// MAR/MDR memory interface: latches address/data from the bus and runs single read/write handshakes against a memory port.
// Latency: a strobe at edge N raises mem_req from cycle N+1. An ack at edge M gives done and valid MDR in cycle M+1, then IDLE.
// Backpressure: the request is held until mem_ack (or until timeout when MEM_TIMEOUT_EN is defined); strobes are ignored while not IDLE.
module mem_interface #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [31:0]       BusMuxInMDR,
    output logic [31:0]       address,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [31:0]       mdr_q, mdr_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             expired;

    // The counter holds the number of wait cycles already spent in the current request.
    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic             expired;

    // Without the timeout build, a request waits for mem_ack forever.
    assign expired = 1'b0;
`endif

    // Next-state, register load and handshake decode.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
                if (MDRin) mdr_d = BusMuxOut;
                // Read wins when both strobes arrive together.
                if (Read) begin
                    state_d = RD_WAIT;
                end else if (Write) begin
                    state_d = WR_WAIT;
                end
`ifdef MEM_TIMEOUT_EN
                if (Read || Write) err_d = 1'b0;
`endif
            end
            RD_WAIT: begin
                if (mem_ack) begin
                    mdr_d   = mem_rdata;
                    state_d = DONE;
                end else if (expired) begin
                    state_d = DONE;
`ifdef MEM_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
`ifdef MEM_TIMEOUT_EN
                if (!mem_ack && !expired) cnt_d = cnt_q + 1'b1;
`endif
            end
            WR_WAIT: begin
                if (mem_ack) begin
                    state_d = DONE;
                end else if (expired) begin
                    state_d = DONE;
`ifdef MEM_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
`ifdef MEM_TIMEOUT_EN
                if (!mem_ack && !expired) cnt_d = cnt_q + 1'b1;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; clear overrides every other input.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Outputs depend only on registered state, never combinationally on inputs.
    assign BusMuxInMDR = mdr_q;
    assign address     = 32'(mar_q);
    assign mem_addr    = mar_q;
    assign mem_wdata   = mdr_q;
    assign mem_req     = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign mem_we      = (state_q == WR_WAIT);
    assign busy        = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_mem_interface.sv
// Directed testbench for mem_interface: reset, read, write, strobe priority, mid-transaction clear and wait/timeout behaviour.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: memory ack is driven by hand at chosen cycles to exercise wait states.
module tb_mem_interface;

    logic        clock;
    logic        clear;
    logic [31:0] BusMuxOut;
    logic        MARin, MDRin, Read, Write;
    logic [31:0] BusMuxInMDR, address;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy, done, err;

    int total = 0;
    int bad   = 0;

    mem_interface #(.ADDR_W(9), .TIMEOUT(16)) dut (
        .clock       (clock),
        .clear       (clear),
        .BusMuxOut   (BusMuxOut),
        .MARin       (MARin),
        .MDRin       (MDRin),
        .Read        (Read),
        .Write       (Write),
        .BusMuxInMDR (BusMuxInMDR),
        .address     (address),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clear     = 1'b1;
        BusMuxOut = 32'hFFFF_FFFF;
        MARin     = 1'b1;
        MDRin     = 1'b1;
        Read      = 1'b1;
        Write     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        // Reset, with load and read strobes active on the same edge.
        tick();
        tick();
        clear = 1'b0; MARin = 1'b0; MDRin = 1'b0; Read = 1'b0;
        check("rst_address", address, 32'h0);
        check("rst_mdr", BusMuxInMDR, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_req", {31'b0, mem_req}, 32'h0);
        check("rst_we", {31'b0, mem_we}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);

        // Read with two wait cycles.
        BusMuxOut = 32'h0000_01A5; MARin = 1'b1;
        tick();
        MARin = 1'b0;
        check("rd_address", address, 32'h0000_01A5);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        check("rd_req_w1", {31'b0, mem_req}, 32'h1);
        check("rd_we_w1", {31'b0, mem_we}, 32'h0);
        check("rd_addr_w1", {23'b0, mem_addr}, 32'h0000_01A5);
        check("rd_busy_w1", {31'b0, busy}, 32'h1);
        check("rd_done_w1", {31'b0, done}, 32'h0);
        tick();
        check("rd_req_w2", {31'b0, mem_req}, 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("rd_done", {31'b0, done}, 32'h1);
        check("rd_mdr", BusMuxInMDR, 32'hDEAD_BEEF);
        check("rd_req_done", {31'b0, mem_req}, 32'h0);
        check("rd_busy_done", {31'b0, busy}, 32'h0);
        tick();
        check("rd_done_once", {31'b0, done}, 32'h0);
        check("rd_idle_busy", {31'b0, busy}, 32'h0);

        // Ack while idle must not touch MDR.
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("idle_ack_mdr", BusMuxInMDR, 32'hDEAD_BEEF);
        check("idle_ack_done", {31'b0, done}, 32'h0);

        // Write, zero-wait ack; a Read offered during DONE is dropped.
        BusMuxOut = 32'h1234_5678; MDRin = 1'b1;
        tick();
        MDRin = 1'b0; BusMuxOut = 32'h0000_0003; MARin = 1'b1;
        tick();
        MARin = 1'b0;
        check("wr_mdr_load", BusMuxInMDR, 32'h1234_5678);
        Write = 1'b1;
        tick();
        Write = 1'b0;
        check("wr_req", {31'b0, mem_req}, 32'h1);
        check("wr_we", {31'b0, mem_we}, 32'h1);
        check("wr_wdata", mem_wdata, 32'h1234_5678);
        check("wr_addr", {23'b0, mem_addr}, 32'h3);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("wr_done", {31'b0, done}, 32'h1);
        check("wr_we_done", {31'b0, mem_we}, 32'h0);
        check("wr_mdr_kept", BusMuxInMDR, 32'h1234_5678);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        check("done_read_ignored", {31'b0, busy}, 32'h0);
        tick();
        check("done_read_still_idle", {31'b0, mem_req}, 32'h0);

        // Read and Write together: Read wins; loads during busy are ignored.
        BusMuxOut = 32'h0000_0055; MARin = 1'b1;
        tick();
        MARin = 1'b0;
        Read = 1'b1; Write = 1'b1;
        tick();
        Read = 1'b0; Write = 1'b0;
        check("both_busy", {31'b0, busy}, 32'h1);
        check("both_we", {31'b0, mem_we}, 32'h0);
        BusMuxOut = 32'h0000_0077; MARin = 1'b1; MDRin = 1'b1; Write = 1'b1;
        tick();
        MARin = 1'b0; MDRin = 1'b0; Write = 1'b0;
        check("busy_mar_kept", address, 32'h0000_0055);
        check("busy_mdr_kept", BusMuxInMDR, 32'h1234_5678);
        check("busy_write_ignored", {31'b0, mem_we}, 32'h0);

        // Clear mid-read, then a late ack.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_req", {31'b0, mem_req}, 32'h0);
        check("clr_done", {31'b0, done}, 32'h0);
        check("clr_mdr", BusMuxInMDR, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_CAFE;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("late_ack_done", {31'b0, done}, 32'h0);
        check("late_ack_mdr", BusMuxInMDR, 32'h0);
        check("late_ack_busy", {31'b0, busy}, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Read with no ack: 16 wait cycles, then DONE with err.
        Read = 1'b1;
        tick();
        Read = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("to_busy_last_wait", {31'b0, busy}, 32'h1);
        tick();
        check("to_done", {31'b0, done}, 32'h1);
        check("to_err", {31'b0, err}, 32'h1);
        check("to_mdr_kept", BusMuxInMDR, 32'h0);
        tick();
        check("to_err_sticky", {31'b0, err}, 32'h1);
        check("to_idle", {31'b0, busy}, 32'h0);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        check("to_err_cleared", {31'b0, err}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        check("to_recover_mdr", BusMuxInMDR, 32'h0BAD_F00D);
        tick();
`else
        // Without timeout the request is held until ack arrives.
        Read = 1'b1;
        tick();
        Read = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("nto_still_busy", {31'b0, busy}, 32'h1);
        check("nto_err", {31'b0, err}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        check("nto_done", {31'b0, done}, 32'h1);
        check("nto_mdr", BusMuxInMDR, 32'h0BAD_F00D);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
